// File: rtl/axis_frame_checker.sv
// axis_frame_checker
//   Receive-side traffic checker for the 512-bit XDMA AXI-Stream RX port.
//   It consumes frames produced by the TX frame generator and never stalls
//   the stream for a check. It can optionally apply a fixed backpressure
//   pattern on tready.
//
//   Frame layout (byte 0 = tdata[7:0] of the first beat):
//     bytes [1:0]  total frame length L in bytes, little-endian
//     bytes [5:2]  sequence number S, little-endian
//     byte  i>=6   (S[7:0] + i) mod 256, with i = KEEP_WIDTH*beat + lane
//
// Ports
//   CLK, RST_N            rising-edge clock, synchronous active-low reset
//   xdma_rx_axis_*        AXI-Stream slave (tvalid/tready/tdata/tkeep/tlast/tuser)
//   frame_ok, frame_err   one-cycle result pulse, one cycle after the tlast beat
//   err_flags             sticky {user, keep, data, seq, len}, bit 0 = len
//   frame_cnt             frames completed (pass + fail), wraps
//   err_frame_cnt         frames that failed, wraps
//   last_seq              sequence number of the most recent completed frame
module axis_frame_checker #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int CNT_WIDTH  = 32,
  parameter int BP_PERIOD  = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  xdma_rx_axis_tvalid,
  output logic                  xdma_rx_axis_tready,
  input  logic [DATA_WIDTH-1:0] xdma_rx_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] xdma_rx_axis_tkeep,
  input  logic                  xdma_rx_axis_tlast,
  input  logic [USER_WIDTH-1:0] xdma_rx_axis_tuser,
  output logic                  frame_ok,
  output logic                  frame_err,
  output logic [4:0]            err_flags,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  err_frame_cnt,
  output logic [31:0]           last_seq
);

  // Error flag bit positions
  localparam int F_LEN  = 0;
  localparam int F_SEQ  = 1;
  localparam int F_DATA = 2;
  localparam int F_KEEP = 3;
  localparam int F_USER = 4;

  localparam int KCW = $clog2(KEEP_WIDTH + 1);
  // Byte-index advance per beat, reduced mod 256 for the payload pattern
  localparam logic [7:0] KW8 = 8'(KEEP_WIDTH % 256);

  // Backpressure: periods below 2 mean tready is never withdrawn
  localparam bit BP_ON   = (BP_PERIOD >= 2);
  localparam int BPW     = BP_ON ? $clog2(BP_PERIOD) : 1;
  localparam int BP_LAST = BP_ON ? BP_PERIOD - 1 : 0;

  typedef enum logic {
    ST_HDR  = 1'b0,
    ST_BODY = 1'b1
  } state_t;

  // Control state (reset)
  state_t               state_q, state_d;
  logic                 seq_valid_q, seq_valid_d;
  logic [BPW-1:0]       bp_cnt_q, bp_cnt_d;
  logic                 tready_q, tready_d;
  logic                 frame_ok_q, frame_ok_d;
  logic                 frame_err_q, frame_err_d;
  logic [4:0]           err_flags_q, err_flags_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0] err_frame_cnt_q, err_frame_cnt_d;
  logic [31:0]          last_seq_q, last_seq_d;

  // Per-frame data state (always rewritten by a header beat before use)
  logic [15:0]          len_q, len_d;
  logic [31:0]          seq_q, seq_d;
  logic [7:0]           beat_q, beat_d;
  logic [15:0]          byte_cnt_q, byte_cnt_d;
  logic                 ovf_q, ovf_d;
  logic [4:0]           pend_q, pend_d;
  logic [31:0]          exp_q, exp_d;

  // Per-beat evaluation
  logic                 acc;
  logic                 hdr;
  logic [15:0]          cur_len;
  logic [31:0]          cur_seq;
  logic [7:0]           cur_beat;
  logic [7:0]           base;
  logic [KCW-1:0]       pop;
  logic [15:0]          prev_cnt;
  logic                 prev_ovf;
  logic [4:0]           prev_pend;
  logic [16:0]          sum;
  logic                 new_ovf;
  logic [15:0]          new_cnt;
  logic                 data_bad;
  logic                 keep_bad;
  logic                 user_bad;
  logic                 len_bad;
  logic                 seq_bad;
  logic [4:0]           beat_flags;
  logic [4:0]           frame_flags;
  logic [KEEP_WIDTH-1:0] keep_p1;

  assign acc = xdma_rx_axis_tvalid & tready_q;
  assign hdr = (state_q == ST_HDR);

  // On a header beat the frame fields come straight from the bus, so the
  // header and a single-beat frame are judged in the same acceptance cycle.
  always_comb begin
    cur_len   = hdr ? xdma_rx_axis_tdata[15:0]  : len_q;
    cur_seq   = hdr ? xdma_rx_axis_tdata[47:16] : seq_q;
    cur_beat  = hdr ? 8'd0 : beat_q;
    prev_cnt  = hdr ? 16'd0 : byte_cnt_q;
    prev_ovf  = hdr ? 1'b0 : ovf_q;
    prev_pend = hdr ? 5'd0 : pend_q;
    // Beat counter wraps at 256, which is harmless: the pattern is mod 256
    base      = cur_seq[7:0] + cur_beat * KW8;
  end

  always_comb begin
    pop = '0;
    for (int l = 0; l < KEEP_WIDTH; l++) begin
      pop = pop + KCW'(xdma_rx_axis_tkeep[l]);
    end
  end

  always_comb begin
    data_bad = 1'b0;
    for (int l = 0; l < KEEP_WIDTH; l++) begin
      // Header lanes 0..5 carry L and S, not pattern bytes
      if (xdma_rx_axis_tkeep[l] && !(hdr && (l < 6)) &&
          (xdma_rx_axis_tdata[8*l +: 8] != (base + 8'(l)))) begin
        data_bad = 1'b1;
      end
    end
  end

  always_comb begin
    // Byte count saturates; the sticky overflow bit keeps a saturated count
    // from ever matching L = 65535 by accident.
    sum      = {1'b0, prev_cnt} + 17'(pop);
    new_ovf  = prev_ovf | sum[16];
    new_cnt  = sum[16] ? 16'hFFFF : sum[15:0];
    keep_p1  = xdma_rx_axis_tkeep + KEEP_WIDTH'(1);
    // A last beat must be a non-empty run of ones starting at lane 0
    if (xdma_rx_axis_tlast) begin
      keep_bad = (xdma_rx_axis_tkeep == '0) ||
                 ((xdma_rx_axis_tkeep & keep_p1) != '0);
    end else begin
      keep_bad = ~(&xdma_rx_axis_tkeep);
    end
    user_bad = xdma_rx_axis_tuser[0];
    len_bad  = new_ovf || (new_cnt != cur_len) || (cur_len < 16'd64);
    seq_bad  = seq_valid_q && (cur_seq != exp_q);

    beat_flags         = '0;
    beat_flags[F_USER] = user_bad;
    beat_flags[F_KEEP] = keep_bad;
    beat_flags[F_DATA] = data_bad;

    frame_flags        = prev_pend | beat_flags;
    frame_flags[F_SEQ] = seq_bad;
    frame_flags[F_LEN] = len_bad;
  end

  always_comb begin
    state_d         = state_q;
    seq_valid_d     = seq_valid_q;
    frame_ok_d      = 1'b0;
    frame_err_d     = 1'b0;
    err_flags_d     = err_flags_q;
    frame_cnt_d     = frame_cnt_q;
    err_frame_cnt_d = err_frame_cnt_q;
    last_seq_d      = last_seq_q;
    len_d           = len_q;
    seq_d           = seq_q;
    beat_d          = beat_q;
    byte_cnt_d      = byte_cnt_q;
    ovf_d           = ovf_q;
    pend_d          = pend_q;
    exp_d           = exp_q;

    // Free-running backpressure phase; tready is registered from its next value
    if (BP_ON) begin
      bp_cnt_d = (bp_cnt_q == BPW'(BP_LAST)) ? '0 : bp_cnt_q + BPW'(1);
    end else begin
      bp_cnt_d = '0;
    end
    tready_d = !(BP_ON && (bp_cnt_d == BPW'(BP_LAST)));

    if (acc) begin
      len_d      = cur_len;
      seq_d      = cur_seq;
      beat_d     = cur_beat + 8'd1;
      byte_cnt_d = new_cnt;
      ovf_d      = new_ovf;
      pend_d     = prev_pend | beat_flags;

      if (xdma_rx_axis_tlast) begin
        // Completion: results become visible the cycle after tlast
        state_d         = ST_HDR;
        frame_ok_d      = ~(|frame_flags);
        frame_err_d     = |frame_flags;
        frame_cnt_d     = frame_cnt_q + CNT_WIDTH'(1);
        err_frame_cnt_d = err_frame_cnt_q + CNT_WIDTH'(|frame_flags);
        err_flags_d     = err_flags_q | frame_flags;
        last_seq_d      = cur_seq;
        // Resynchronise on whatever arrived, even if it was out of order
        seq_valid_d     = 1'b1;
        exp_d           = cur_seq + 32'd1;
      end else begin
        state_d = ST_BODY;
      end
    end
  end

  always_ff @(posedge CLK) begin
    len_q      <= len_d;
    seq_q      <= seq_d;
    beat_q     <= beat_d;
    byte_cnt_q <= byte_cnt_d;
    ovf_q      <= ovf_d;
    pend_q     <= pend_d;
    exp_q      <= exp_d;
    if (!RST_N) begin
      state_q         <= ST_HDR;
      seq_valid_q     <= 1'b0;
      bp_cnt_q        <= '0;
      tready_q        <= 1'b0;
      frame_ok_q      <= 1'b0;
      frame_err_q     <= 1'b0;
      err_flags_q     <= '0;
      frame_cnt_q     <= '0;
      err_frame_cnt_q <= '0;
      last_seq_q      <= '0;
    end else begin
      state_q         <= state_d;
      seq_valid_q     <= seq_valid_d;
      bp_cnt_q        <= bp_cnt_d;
      tready_q        <= tready_d;
      frame_ok_q      <= frame_ok_d;
      frame_err_q     <= frame_err_d;
      err_flags_q     <= err_flags_d;
      frame_cnt_q     <= frame_cnt_d;
      err_frame_cnt_q <= err_frame_cnt_d;
      last_seq_q      <= last_seq_d;
    end
  end

  assign xdma_rx_axis_tready = tready_q;
  assign frame_ok            = frame_ok_q;
  assign frame_err           = frame_err_q;
  assign err_flags           = err_flags_q;
  assign frame_cnt           = frame_cnt_q;
  assign err_frame_cnt       = err_frame_cnt_q;
  assign last_seq            = last_seq_q;

endmodule

// File: doc/axis_frame_checker.md
Name: axis_frame_checker

Overview:
- Receive-side traffic checker for the 512-bit XDMA AXI-Stream RX port of the UDP/CMAC datapath.
- It is the consumer counterpart of the TX-side frame generator. It accepts frames from xdma_rx_axis and drives tready with an optional backpressure pattern.
- Each frame is checked for header length, sequence number, tkeep shape and payload pattern.
- It exports per-frame result pulses, sticky error flags and counters for the simulation bench and for on-board ILA/CSR readout.

Parameters:
- DATA_WIDTH, 512, AXIS tdata width in bits; must equal 8*KEEP_WIDTH.
- KEEP_WIDTH, 64, AXIS tkeep width (bytes per beat).
- USER_WIDTH, 1, AXIS tuser width; only bit 0 is used.
- CNT_WIDTH, 32, width of the frame and error counters.
- BP_PERIOD, 0, backpressure period; 0 = tready always high, N>=2 = tready low exactly 1 cycle in every N.

Ports:
- CLK  in  1  Single clock; all logic is rising-edge.
- RST_N  in  1  Synchronous, active-low reset.
- xdma_rx_axis_tvalid  in  1  Beat valid.
- xdma_rx_axis_tready  out  1  Checker ready.
- xdma_rx_axis_tdata  in  DATA_WIDTH  Beat data; byte 0 = bits [7:0].
- xdma_rx_axis_tkeep  in  KEEP_WIDTH  Byte enables.
- xdma_rx_axis_tlast  in  1  Last beat of frame.
- xdma_rx_axis_tuser  in  USER_WIDTH  Bit 0 = upstream error mark.
- frame_ok  out  1  One-cycle pulse: frame passed all checks.
- frame_err  out  1  One-cycle pulse: frame failed at least one check.
- err_flags  out  5  Sticky flags {user, keep, data, seq, len}; bit 0 = len.
- frame_cnt  out  CNT_WIDTH  Frames completed (pass + fail).
- err_frame_cnt  out  CNT_WIDTH  Frames that failed.
- last_seq  out  32  Sequence number of the most recent completed frame.

Behaviour:
- Handshake: a beat is accepted when tvalid & tready. No check ever stalls the stream.
- tready never depends on tvalid.
- Backpressure counter runs modulo BP_PERIOD; tready = 0 when the counter equals BP_PERIOD-1.
- Reset: while RST_N = 0, at the clock edge:
  - tready = 0; frame_ok, frame_err, err_flags, frame_cnt, err_frame_cnt and last_seq = 0.
  - State = HDR, seq_valid = 0, backpressure counter = 0.
  - tready rises on the first cycle after RST_N goes high. A frame in flight when reset asserts is discarded with no counts or flags.
- Frame format:
  - Header bytes [1:0] = total frame length L in bytes, little-endian.
  - Header bytes [5:2] = sequence S, little-endian.
  - Byte at absolute index i >= 6 = (S[7:0] + i) mod 256, where i = 64*beat + lane.
- State machine HDR:
  - Waits for an accepted beat, latches L, S and seed, and sets byte count = popcount(tkeep).
  - Goes to BODY if tlast = 0.
  - If tlast = 1, completes the frame in the same acceptance cycle.
- State machine BODY: accumulates byte count and checks each beat; goes to HDR on an accepted tlast beat.
- No DRAIN state: after an error is detected the frame is still consumed to tlast, and the error is latched into a per-frame pending vector.
- Checks, evaluated per accepted beat and ORed into the pending vector:
  - keep: a non-last beat must have tkeep all ones. A last beat must have tkeep non-zero and contiguous from bit 0.
  - data: every enabled lane with i >= 6 must match the pattern. Disabled lanes are ignored.
  - user: tuser[0] = 1 on any beat.
  - len: final byte count != L, or L < 64, or byte count would exceed 65535. The counter saturates at 65535.
  - seq: seq_valid = 1 and S != expected, where expected = previous S + 1 mod 2^32. The first frame after reset only seeds expected.
- Completion, registered one cycle after the tlast acceptance:
  - frame_ok or frame_err pulses for exactly 1 cycle.
  - frame_cnt increments; err_frame_cnt increments on failure; err_flags |= pending; last_seq = S.
  - seq_valid is set and expected = S + 1, even on a seq error, so the checker resynchronises.
- Back-to-back frames: a header beat may be accepted the cycle right after a tlast beat. Completion of the previous frame and header capture of the next overlap without loss.
- Counters wrap modulo 2^CNT_WIDTH. err_flags clear only on reset.

Test Plan:
- Three frames of L=64, S=0,1,2, BP_PERIOD=0 -> 3 frame_ok pulses, each 1 cycle after its tlast; frame_cnt=3, err_flags=0, last_seq=2.
- Frame L=200 (4 beats, last tkeep=0x00FF), S=0xFFFFFFFF, then S=0 -> both pass (seq wrap), frame_cnt=2.
- Frame S=5 followed by S=7 -> second frame gives frame_err, err_flags=5'b00010, err_frame_cnt=1; next frame S=8 passes.
- L field=128 with 192 bytes sent; separately, lane 10 of beat 1 corrupted -> err_flags bits len and data set, err_frame_cnt=2.
- Last beat tkeep=0x0F0F; separately, tuser=1 on a middle beat -> err_flags bits keep and user set.
- BP_PERIOD=3 with 100 back-to-back 128-byte frames, then RST_N low 1 cycle mid-frame -> tready low every 3rd cycle, 100 frame_ok pulses; after reset all outputs are 0 and the next clean frame passes.
